// File: rtl/btn_debounce_pulse.sv
// -----------------------------------------------------------------------------
// btn_debounce_pulse
//
// Purpose:
//   Debounces a raw mechanical push-button. The raw level is synchronized into
//   the clock domain, sampled once every TICK_DIV cycles, and a level change is
//   only accepted after STABLE_TICKS consecutive samples agree with it. Each
//   accepted change produces a one-cycle press or release pulse.
//
// Parameters:
//   TICK_DIV     - sample-tick period in in_clk cycles (2 .. 2^26)
//   STABLE_TICKS - consecutive agreeing samples needed to accept (2 .. 15)
//
// Ports:
//   in_clk      in   sole clock, all logic on the rising edge
//   rst         in   synchronous active-high reset
//   btn_in      in   raw asynchronous bouncing button level
//   btn_level   out  debounced (registered) button level
//   btn_press   out  one-cycle pulse on an accepted 0->1 change
//   btn_release out  one-cycle pulse on an accepted 1->0 change
//   sample_tick out  one-cycle strobe marking each sample instant
// -----------------------------------------------------------------------------
module btn_debounce_pulse #(
    parameter int TICK_DIV     = 250000,
    parameter int STABLE_TICKS = 4
) (
    input  logic in_clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic sample_tick
);

    // FSM encoding
    localparam logic [1:0] LOW       = 2'd0;
    localparam logic [1:0] WAIT_HIGH = 2'd1;
    localparam logic [1:0] HIGH      = 2'd2;
    localparam logic [1:0] WAIT_LOW  = 2'd3;

    localparam logic [25:0] TICK_LAST   = 26'(TICK_DIV - 1);
    localparam logic [3:0]  STABLE_LAST = 4'(STABLE_TICKS - 1);

    logic        syncMeta_q;
    logic        syncBtn_q;
    logic [25:0] tickCnt_q;
    logic [25:0] tickCnt_d;
    logic        tick_q;
    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [3:0]  stableCnt_q;
    logic [3:0]  stableCnt_d;
    logic        level_q;
    logic        level_d;
    logic        press_q;
    logic        press_d;
    logic        release_q;
    logic        release_d;

    // Two-flop synchronizer; only syncBtn_q is ever looked at downstream.
    always_ff @(posedge in_clk) begin
        if (rst) begin
            syncMeta_q <= 1'b0;
            syncBtn_q  <= 1'b0;
        end else begin
            syncMeta_q <= btn_in;
            syncBtn_q  <= syncMeta_q;
        end
    end

    // Free-running sample divider that wraps at TICK_DIV-1.
    always_comb begin
        tickCnt_d = tickCnt_q + 26'd1;
        if (tickCnt_q == TICK_LAST) begin
            tickCnt_d = '0;
        end
    end

    // The strobe is registered from the next count value so that it is high
    // exactly while the count sits at TICK_DIV-1, without a decode glitch.
    // It is used purely as a clock enable for the FSM below.
    always_ff @(posedge in_clk) begin
        if (rst) begin
            tickCnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            tickCnt_q <= tickCnt_d;
            tick_q    <= (tickCnt_d == TICK_LAST);
        end
    end

    // Debounce FSM. The WAIT_* states count agreeing samples; any disagreeing
    // sample throws the partial count away and falls back to the stable state.
    // btn_level and the pulses are computed from the accepting transition so
    // they register on the same edge as the state change.
    always_comb begin
        state_d     = state_q;
        stableCnt_d = stableCnt_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        if (tick_q) begin
            case (state_q)
                LOW: begin
                    if (syncBtn_q) begin
                        state_d     = WAIT_HIGH;
                        stableCnt_d = 4'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (!syncBtn_q) begin
                        state_d     = LOW;
                        stableCnt_d = 4'd0;
                    end else if (stableCnt_q == STABLE_LAST) begin
                        state_d     = HIGH;
                        stableCnt_d = 4'd0;
                        level_d     = 1'b1;
                        press_d     = 1'b1;
                    end else begin
                        stableCnt_d = stableCnt_q + 4'd1;
                    end
                end
                HIGH: begin
                    if (!syncBtn_q) begin
                        state_d     = WAIT_LOW;
                        stableCnt_d = 4'd1;
                    end
                end
                WAIT_LOW: begin
                    if (syncBtn_q) begin
                        state_d     = HIGH;
                        stableCnt_d = 4'd0;
                    end else if (stableCnt_q == STABLE_LAST) begin
                        state_d     = LOW;
                        stableCnt_d = 4'd0;
                        level_d     = 1'b0;
                        release_d   = 1'b1;
                    end else begin
                        stableCnt_d = stableCnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d     = LOW;
                    stableCnt_d = 4'd0;
                    level_d     = 1'b0;
                end
            endcase
        end
    end

    // Reset clears everything, which also truncates any pulse in flight and
    // forces a held button to be re-qualified from LOW.
    always_ff @(posedge in_clk) begin
        if (rst) begin
            state_q     <= LOW;
            stableCnt_q <= 4'd0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stableCnt_q <= stableCnt_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign sample_tick = tick_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce_pulse
//
// Scoreboard bench for btn_debounce_pulse with TICK_DIV=4, STABLE_TICKS=3.
// The driver applies one input vector per clock and advances a behavioural
// model: the button value seen at a sample instant is the raw input from two
// edges earlier, samples happen every TICK_DIV cycles counted from reset, and
// the debounced level flips once STABLE_TICKS consecutive samples disagree
// with it. Expected per-cycle outputs and expected pulse events are queued;
// a separate monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_btn_debounce_pulse;

    localparam int TD = 4;
    localparam int ST = 3;

    logic in_clk = 1'b0;
    logic rst    = 1'b1;
    logic btn_in = 1'b0;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic sample_tick;

    always #5 in_clk = ~in_clk;

    btn_debounce_pulse #(
        .TICK_DIV    (TD),
        .STABLE_TICKS(ST)
    ) dut (
        .in_clk     (in_clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .sample_tick(sample_tick)
    );

    typedef struct {
        int   edgeNo;
        logic level;
        logic tick;
    } cycExp_t;

    typedef struct {
        int   edgeNo;
        logic isPress;
    } evExp_t;

    cycExp_t cycQ[$];
    evExp_t  evQ[$];

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state
    int   edgeNo = 0;
    int   mPhase = 0;
    int   mRun   = 0;
    logic mLevel = 1'b0;
    logic histQ[$] = '{1'b0, 1'b0};

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edgeNo, actual, expected);
        end
    endtask

    // Drive one vector for the coming rising edge and advance the model.
    task automatic applyStimulus(input logic r, input logic b);
        logic   seen;
        evExp_t ev;
        cycExp_t ce;
        @(posedge in_clk);
        #2;
        rst    = r;
        btn_in = b;
        edgeNo++;
        if (r) begin
            histQ  = '{1'b0, 1'b0};
            mPhase = 0;
            mRun   = 0;
            mLevel = 1'b0;
        end else begin
            seen = histQ[0];
            if (mPhase == TD - 1) begin
                if (seen != mLevel) begin
                    mRun++;
                    if (mRun == ST) begin
                        mLevel     = seen;
                        mRun       = 0;
                        ev.edgeNo  = edgeNo;
                        ev.isPress = seen;
                        evQ.push_back(ev);
                    end
                end else begin
                    mRun = 0;
                end
            end
            void'(histQ.pop_front());
            histQ.push_back(b);
            mPhase = (mPhase + 1) % TD;
        end
        ce.edgeNo = edgeNo;
        ce.level  = mLevel;
        ce.tick   = (mPhase == TD - 1);
        cycQ.push_back(ce);
    endtask

    // Monitor: the newest queue entry belongs to the edge still to come, so
    // only pop when an older one is waiting.
    initial begin
        cycExp_t ce;
        evExp_t  ev;
        forever begin
            @(negedge in_clk);
            if (cycQ.size() >= 2) begin
                ce = cycQ.pop_front();
                checkOutput("btn_level", int'(btn_level), int'(ce.level));
                checkOutput("sample_tick", int'(sample_tick), int'(ce.tick));
                if (btn_press && btn_release) begin
                    checkOutput("press_and_release_together", 1, 0);
                end
                if (btn_press || btn_release) begin
                    if (evQ.size() == 0) begin
                        checkOutput("unexpected_pulse_edge", ce.edgeNo, -1);
                    end else begin
                        ev = evQ.pop_front();
                        checkOutput("pulse_kind_press", int'(btn_press), int'(ev.isPress));
                        checkOutput("pulse_edge", ce.edgeNo, ev.edgeNo);
                    end
                end
            end
        end
    end

    initial begin
        logic b;
        int   len;
        int   style;
        logic lvl;
        int   glitchAt;

        $display("[TB] start TICK_DIV=%0d STABLE_TICKS=%0d", TD, ST);
        repeat (3) applyStimulus(1'b1, 1'b0);

        // Idle after reset: only the sample strobe moves
        repeat (20) applyStimulus(1'b0, 1'b0);

        // Clean press and hold, then clean release and hold
        repeat (30) applyStimulus(1'b0, 1'b1);
        repeat (30) applyStimulus(1'b0, 1'b0);

        // Two agreeing samples then a disagreeing one: no press
        for (int i = 0; i < 40 && mRun != 2; i++) applyStimulus(1'b0, 1'b1);
        repeat (20) applyStimulus(1'b0, 1'b0);

        // Input toggles every cycle but is high at every sample instant
        b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ((mPhase + 2) % TD == TD - 1) b = 1'b1;
            else b = ~b;
            applyStimulus(1'b0, b);
        end
        repeat (30) applyStimulus(1'b0, 1'b0);

        // Reset in WAIT_HIGH with two agreeing samples, button kept held
        for (int i = 0; i < 40 && mRun != 2; i++) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        repeat (30) applyStimulus(1'b0, 1'b1);

        // Reset right as a press pulse is showing
        repeat (30) applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 60 && evQ.size() == 0; i++) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        repeat (30) applyStimulus(1'b0, 1'b0);

        // Randomized segments: steady levels, noise, and single-cycle glitches
        for (int seg = 0; seg < 250; seg++) begin
            len      = int'($urandom_range(1, 25));
            style    = int'($urandom_range(0, 2));
            lvl      = 1'($urandom_range(0, 1));
            glitchAt = int'($urandom_range(0, 24));
            for (int i = 0; i < len; i++) begin
                case (style)
                    0: b = lvl;
                    1: b = 1'($urandom_range(0, 1));
                    default: b = (i == glitchAt) ? ~lvl : lvl;
                endcase
                applyStimulus(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, b);
            end
        end

        // Drain with reset held so nothing new is expected
        repeat (4) applyStimulus(1'b1, 1'b0);
        @(negedge in_clk);
        @(negedge in_clk);
        checkOutput("pending_expected_pulses", evQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/btn_debounce_pulse.md
BTN_DEBOUNCE_PULSE -- requirements
Module: btn_debounce_pulse

Interface
REQ-001 SHALL have parameter TICK_DIV, default 250000, sample-tick period in in_clk cycles; legal range 2..2^26.
REQ-002 SHALL have parameter STABLE_TICKS, default 4, consecutive agreeing samples needed to accept a level change; legal range 2..15.
REQ-003 SHALL have port in_clk, input, 1 bit, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-005 SHALL have port btn_in, input, 1 bit, raw asynchronous bouncing button level.
REQ-006 SHALL have port btn_level, output, 1 bit, debounced button level.
REQ-007 SHALL have port btn_press, output, 1 bit, one-cycle pulse on an accepted 0->1 change.
REQ-008 SHALL have port btn_release, output, 1 bit, one-cycle pulse on an accepted 1->0 change.
REQ-009 SHALL have port sample_tick, output, 1 bit, one-cycle strobe marking each sample instant; observability only.

Function
REQ-010 SHALL pass btn_in through a 2-flop synchronizer; the FSM SHALL see only the synchronized value sync_btn.
REQ-011 SHALL run a 26-bit tick counter 0..TICK_DIV-1 that wraps to 0; sample_tick SHALL be 1 exactly in the cycle where count == TICK_DIV-1.
REQ-012 SHALL not derive a clock from the tick; the tick SHALL act only as a clock enable.
REQ-013 SHALL implement FSM states LOW, WAIT_HIGH, HIGH, WAIT_LOW, plus a 4-bit agreement counter stable_cnt.
REQ-014 SHALL change state and stable_cnt only in sample_tick cycles; all other cycles hold.
REQ-015 LOW on tick: if sync_btn=1, go to WAIT_HIGH with stable_cnt=1; otherwise stay.
REQ-016 WAIT_HIGH on tick: if sync_btn=0, go to LOW with stable_cnt=0.
REQ-017 WAIT_HIGH on tick: if sync_btn=1 and stable_cnt==STABLE_TICKS-1, go to HIGH with stable_cnt=0.
REQ-018 WAIT_HIGH on tick: if sync_btn=1 and stable_cnt<STABLE_TICKS-1, increment stable_cnt.
REQ-019 HIGH and WAIT_LOW SHALL mirror REQ-015..018 with the polarities inverted; WAIT_LOW accepts into LOW.
REQ-020 btn_level SHALL be registered: 1 in HIGH and WAIT_LOW, 0 in LOW and WAIT_HIGH; it changes at the same edge as the accepting transition.
REQ-021 btn_press SHALL be 1 for exactly the one cycle following the WAIT_HIGH->HIGH edge; btn_release likewise for WAIT_LOW->LOW.
REQ-022 btn_press and btn_release SHALL never be 1 in the same cycle and SHALL never assert without a btn_level change.
REQ-023 Any glitch shorter than the tick period and not present at a sample instant SHALL have no effect.
REQ-024 A disagreeing sample in WAIT_* SHALL return the FSM to the prior stable state with no pulse; partial agreement counts SHALL be discarded.
REQ-025 Worst-case acceptance latency SHALL be 2 cycles (synchronizer) plus STABLE_TICKS*TICK_DIV cycles, plus 1 cycle to the pulse.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL clear synchronizer flops, tick counter, stable_cnt, state (to LOW), btn_level, btn_press, btn_release and sample_tick to 0.
REQ-027 A reset asserted mid-debounce or mid-pulse SHALL truncate the pulse in the next cycle and SHALL produce no press or release pulse.
REQ-028 After rst deasserts, the first sample_tick SHALL occur TICK_DIV cycles later.
REQ-029 If btn_in is held at 1 through reset, the block SHALL re-qualify it as a new press per REQ-015..018.

Verification (TICK_DIV=4, STABLE_TICKS=3)
REQ-030 Reset release, btn_in=0 -> sample_tick pulses every 4th cycle, first one 4 cycles after release; all other outputs stay 0.
REQ-031 btn_in rises cleanly and holds -> btn_level rises at the 3rd tick that samples high; btn_press is 1 for exactly 1 cycle; the transition completes within 2+12+1 cycles.
REQ-032 btn_in high for 2 samples, then low at the 3rd sample -> FSM returns to LOW; no btn_press; btn_level stays 0.
REQ-033 btn_in toggles every cycle between sample instants, yet is 1 at each sample -> treated as stable; press accepted after 3 ticks.
REQ-034 From HIGH, btn_in falls and holds -> btn_release pulses 1 cycle and btn_level=0 after 3 low samples; btn_press stays 0.
REQ-035 rst pulsed for 1 cycle while in WAIT_HIGH with stable_cnt=2 -> all outputs 0 next cycle; the held button needs 3 fresh ticks to produce btn_press.
